// File: rtl/rv_sram_arbiter.sv
// Two-port arbiter sharing the single-port SRAM driver between instruction fetch and load/store.
// Optional round-robin arbitration is enabled by defining RV_SRAM_ARB_RR_EN (default: data port has fixed priority).
module rv_sram_arbiter #(
    parameter int unsigned SRAM_BYTES = 2097152,
    parameter int unsigned XLEN       = 32
) (
    input  logic              clk_i,
    input  logic              arstn_i,

    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int unsigned BEW = XLEN / 8;
    // Wrap into the SRAM and force word alignment in a single mask.
    localparam logic [XLEN-1:0] ADDR_MASK = XLEN'(SRAM_BYTES - 1) & ~XLEN'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    state_e          state_q, state_d;
    port_e           owner_q, owner_d;
    port_e           last_q, last_d;
    logic            we_q, we_d;
    logic [BEW-1:0]  be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            instr_rvalid_q, instr_rvalid_d;
    logic            data_rvalid_q, data_rvalid_d;
    logic [XLEN-1:0] instr_rdata_q, instr_rdata_d;
    logic [XLEN-1:0] data_rdata_q, data_rdata_d;
    logic            instr_gnt, data_gnt;
    logic            data_wins;

`ifdef RV_SRAM_ARB_RR_EN
    // On contention the port that was not served last wins.
    assign data_wins = data_req_i && (!instr_req_i || (last_q == PORT_INSTR));
`else
    assign data_wins = data_req_i;
`endif

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        we_d           = we_q;
        be_d           = be_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        instr_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        instr_rdata_d  = instr_rdata_q;
        data_rdata_d   = data_rdata_q;
        instr_gnt      = 1'b0;
        data_gnt       = 1'b0;

        case (state_q)
            IDLE: begin
                if (data_wins) begin
                    data_gnt = 1'b1;
                    we_d     = data_we_i;
                    be_d     = data_be_i;
                    addr_d   = data_addr_i & ADDR_MASK;
                    wdata_d  = data_wdata_i;
                    owner_d  = PORT_DATA;
                    state_d  = ISSUE;
                end else if (instr_req_i) begin
                    instr_gnt = 1'b1;
                    we_d      = 1'b0;
                    be_d      = {BEW{1'b1}};
                    addr_d    = instr_addr_i & ADDR_MASK;
                    owner_d   = PORT_INSTR;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    if (owner_q == PORT_DATA) begin
                        data_rvalid_d = 1'b1;
                        data_rdata_d  = mem_rdata_i;
                    end else begin
                        instr_rvalid_d = 1'b1;
                        instr_rdata_d  = mem_rdata_i;
                    end
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q        <= IDLE;
            owner_q        <= PORT_INSTR;
            last_q         <= PORT_INSTR;
            we_q           <= 1'b0;
            be_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            instr_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            instr_rdata_q  <= '0;
            data_rdata_q   <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            we_q           <= we_d;
            be_q           <= be_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            instr_rvalid_q <= instr_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            instr_rdata_q  <= instr_rdata_d;
            data_rdata_q   <= data_rdata_d;
        end
    end

    // Grants are combinational, so they must be masked explicitly while in reset.
    assign instr_gnt_o    = instr_gnt & arstn_i;
    assign data_gnt_o     = data_gnt & arstn_i;
    assign instr_rvalid_o = instr_rvalid_q;
    assign instr_rdata_o  = instr_rdata_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign data_rdata_o   = data_rdata_q;
    assign mem_req_o      = (state_q == ISSUE);
    assign mem_we_o       = we_q;
    assign mem_be_o       = be_q;
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = wdata_q;

endmodule

// File: tb/tb_rv_sram_arbiter.sv
// Directed bench for rv_sram_arbiter: a response scoreboard checks every rvalid pulse against queued expectations.
module tb_rv_sram_arbiter;

    logic        clk_i;
    logic        arstn_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    rv_sram_arbiter dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        is_data;
        logic        is_store;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   n_memreq  = 0;
    logic last_data = 1'b0;   // reference model of last_served (1 = data port)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response scoreboard and mem_req pulse counter, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (arstn_i) begin
            if (instr_rvalid_o || data_rvalid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_port", {30'b0, instr_rvalid_o, data_rvalid_o}, e.is_data ? 32'd1 : 32'd2);
                    if (!e.is_store)
                        chk("rsp_rdata", e.is_data ? data_rdata_o : instr_rdata_o, e.rdata);
                    $display("[TB] response port=%s rdata=%h", e.is_data ? "data" : "instr",
                             e.is_data ? data_rdata_o : instr_rdata_o);
                end
            end
            if (mem_req_o) n_memreq++;
        end
    end

    // Called with inputs just driven at a falling edge; checks the grant, then mem_req one cycle later.
    task automatic grant(input logic is_data, input logic drop);
        #1;
        chk(is_data ? "gnt_data" : "gnt_instr", {30'b0, instr_gnt_o, data_gnt_o},
            is_data ? 32'd1 : 32'd2);
        @(negedge clk_i);
        if (drop) begin
            if (is_data) data_req_i = 1'b0;
            else         instr_req_i = 1'b0;
        end
        chk("mem_req_t1", mem_req_o, 1);
    endtask

    // Driver model: checks the issued fields, holds them for lat cycles, then pulses mem_rvalid_i.
    task automatic serve(input int lat, input logic [31:0] rd, input logic we,
                         input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        int k = 0;
        while (!mem_req_o && k < 10) begin
            @(negedge clk_i);
            k++;
        end
        chk("mem_req_seen", mem_req_o, 1);
        chk("mem_we", mem_we_o, we);
        chk("mem_be", mem_be_o, be);
        chk("mem_addr", mem_addr_o, addr);
        if (we) chk("mem_wdata", mem_wdata_o, wd);
        $display("[TB] mem_req we=%0b be=%h addr=%h wdata=%h", mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk_i);
            chk("mem_req_pulse", mem_req_o, 0);
            chk("hold_addr", mem_addr_o, addr);
            chk("hold_be", mem_be_o, be);
            chk("busy_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 32'd0);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd;
        @(negedge clk_i);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        chk("rsp_pulse", {31'b0, instr_rvalid_o | data_rvalid_o}, 32'd1);
    endtask

    // Both ports request; the bench's own last_served model predicts each winner.
    task automatic run_both(input int n);
        logic win_data;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0200;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h0000_0301;
        n_memreq     = 0;
        for (int i = 0; i < n; i++) begin
`ifdef RV_SRAM_ARB_RR_EN
            win_data = !last_data;
`else
            win_data = 1'b1;
`endif
            exp_q.push_back('{is_data: win_data, is_store: 1'b0, rdata: 32'hC0DE_0000 + i});
            grant(win_data, 1'b0);
            if (i == n - 1) begin
                instr_req_i = 1'b0;
                data_req_i  = 1'b0;
            end
            serve(2, 32'hC0DE_0000 + i, 1'b0, 4'hF, win_data ? 32'h0000_0300 : 32'h0000_0200, 32'h0);
            last_data = win_data;
        end
        @(negedge clk_i);
        chk("memreq_count", n_memreq, n);
    endtask

    initial begin
        arstn_i      = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;

        // Reset state, with a request pending that must not be granted.
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 32'd0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);
        chk("rst_rdata", instr_rdata_o | data_rdata_o, 32'h0);
        instr_req_i = 1'b0;
        @(negedge clk_i);
        arstn_i = 1'b1;
        @(negedge clk_i);

        // Instruction fetch, 3-cycle driver latency.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0104;
        exp_q.push_back('{is_data: 1'b0, is_store: 1'b0, rdata: 32'hDEAD_BEEF});
        grant(1'b0, 1'b1);
        serve(3, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0000_0104, 32'h0);
        last_data = 1'b0;
        @(negedge clk_i);
        chk("rvalid_one_cycle", instr_rvalid_o, 0);
        chk("instr_rdata_hold", instr_rdata_o, 32'hDEAD_BEEF);

        // Store: address wraps past 2 MiB and is word aligned.
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_addr_i  = 32'h0020_0013;
        data_wdata_i = 32'h1234_5678;
        exp_q.push_back('{is_data: 1'b1, is_store: 1'b1, rdata: 32'h0});
        grant(1'b1, 1'b1);
        serve(2, 32'h5555_AAAA, 1'b1, 4'h3, 32'h0000_0010, 32'h1234_5678);
        last_data = 1'b1;
        chk("instr_rdata_kept", instr_rdata_o, 32'hDEAD_BEEF);
        @(negedge clk_i);

        // Simultaneous requests, then continuous contention for four transactions.
        run_both(2);
        run_both(4);

        // Stray completion pulses in IDLE must be ignored.
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
        repeat (3) begin
            @(negedge clk_i);
            chk("stray_mem_req", mem_req_o, 0);
            chk("stray_gnt", {30'b0, instr_gnt_o, data_gnt_o}, 32'd0);
        end
        mem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("stray_rvalid", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'd0);

        // Reset while waiting on the driver, with a second request held.
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0040;
        grant(1'b0, 1'b1);
        @(negedge clk_i);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0080;
        #1;
        chk("wait_no_gnt", instr_gnt_o, 0);
        arstn_i = 1'b0;
        #1;
        chk("mid_rst_gnt", instr_gnt_o, 0);
        chk("mid_rst_mem_addr", mem_addr_o, 32'h0);
        chk("mid_rst_be", mem_be_o, 32'h0);
        chk("mid_rst_rdata", instr_rdata_o, 32'h0);
        repeat (2) @(negedge clk_i);
        arstn_i   = 1'b1;
        last_data = 1'b0;
        exp_q.push_back('{is_data: 1'b0, is_store: 1'b0, rdata: 32'h0BAD_F00D});
        grant(1'b0, 1'b1);
        serve(1, 32'h0BAD_F00D, 1'b0, 4'hF, 32'h0000_0080, 32'h0);

        repeat (3) @(negedge clk_i);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
